// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared encodings and lane helpers for the MEM-stage access unit
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Byte enables for an access; loads always fetch the whole word.
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off,
                                         input logic is_store);
    logic [3:0] be;
    be = 4'b1111;
    if (is_store) begin
      case (sz)
        SZ_BYTE: be = 4'b0001 << off;
        SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  // Halfwords must sit on even addresses, words on multiples of four.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (sz)
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - selects the addressed byte/halfword lane and extends it to 32 bits
module load_extract
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        unsigned_ld,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Little-endian lane pick, then sign or zero fill from the lane's top bit.
  always_comb begin
    byte_lane = 8'h00;
    half_lane = 16'h0000;
    ext_data  = rdata;
    case (offset)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: ext_data = {{24{~unsigned_ld & byte_lane[7]}}, byte_lane};
      SZ_HALF: ext_data = {{16{~unsigned_ld & half_lane[15]}}, half_lane};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with req/ack data memory handshake
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        done,
  output logic        addr_err,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(ACK_TIMEOUT);

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              uns_q, uns_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              addr_err_q, addr_err_d;
  logic              bus_err_q, bus_err_d;

  logic              op_illegal;
  logic              op_ok;
  logic              accept;
  logic [31:0]       store_data;
  logic [31:0]       ext_data;

  assign op_illegal = (mem_read == mem_write) | (size == SZ_ILL);
  assign op_ok      = ~op_illegal & ~is_misaligned(size, addr[1:0]);
  assign accept     = (state_q == ST_IDLE) & start & op_ok;

  // Freeze the pipeline from the accepting cycle until the access retires.
  assign stall      = accept | (state_q == ST_BUSY);

  assign dmem_req   = (state_q == ST_BUSY);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign rdata_out  = rdata_q;
  assign done       = done_q;
  assign addr_err   = addr_err_q;
  assign bus_err    = bus_err_q;

  // Replicate the store value across every lane it could land in.
  always_comb begin
    store_data = wdata;
    case (size)
      SZ_BYTE: store_data = {4{wdata[7:0]}};
      SZ_HALF: store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  end

  load_extract u_load_extract (
    .rdata       (dmem_rdata),
    .size        (size_q),
    .offset      (off_q),
    .unsigned_ld (uns_q),
    .ext_data    (ext_data)
  );

  // Next-state logic: accept/reject in IDLE, wait for ack or timeout in BUSY.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    off_d      = off_q;
    uns_d      = uns_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    addr_err_d = 1'b0;
    bus_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op_ok) begin
            we_d    = mem_write;
            addr_d  = {addr[31:2], 2'b00};
            be_d    = lane_be(size, addr[1:0], mem_write);
            wdata_d = store_data;
            size_d  = size;
            off_d   = addr[1:0];
            uns_d   = unsigned_ld;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        // An ack arriving on the timeout cycle still completes the access.
        if (dmem_ack) begin
          if (!we_q) begin
            rdata_d = ext_data;
          end
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if ((cnt_q + TMO_W'(1)) == TMO_LIM) begin
          bus_err_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered request/response with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      off_q      <= '0;
      uns_q      <= 1'b0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      off_q      <= off_d;
      uns_q      <= uns_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mem_read, mem_write, unsigned_ld, dmem_ack;
  logic [1:0]  size;
  logic [31:0] addr, wdata, dmem_rdata;
  logic        stall, done, addr_err, bus_err, dmem_req, dmem_we;
  logic [31:0] rdata_out, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0, berr_cnt = 0, aerr_cnt = 0, req_cnt = 0;
  int stalls;
  int d0, b0, a0, r0;
  logic        cap_req, cap_we, prev_done;
  logic [31:0] cap_addr, cap_wdata, prev_rdata;
  logic [3:0]  cap_be;

  always #5 clk = ~clk;

  mem_access_unit #(.ACK_TIMEOUT(4), .TMO_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata_out(rdata_out), .done(done), .addr_err(addr_err),
    .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always @(negedge clk) begin
    if (done)     done_cnt++;
    if (bus_err)  berr_cnt++;
    if (addr_err) aerr_cnt++;
    if (dmem_req) req_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    start = 0; mem_read = 0; mem_write = 0; size = SZ_BYTE; unsigned_ld = 0;
    addr = 0; wdata = 0; dmem_ack = 0; dmem_rdata = 0;
    #1;
  endtask

  // Issue one op, hold garbage inputs with start high while busy, ack on the last busy cycle.
  task automatic mem_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int nwait,
                        input logic ack_it, input logic [31:0] rmem);
    @(negedge clk);
    dmem_ack = 0; dmem_rdata = 0;
    start = 1; mem_read = rd; mem_write = wr; size = sz; unsigned_ld = uns; addr = a; wdata = wd;
    #1;
    prev_done  = done;
    prev_rdata = rdata_out;
    stalls     = int'(stall);
    for (int i = 0; i <= nwait; i++) begin
      @(negedge clk);
      mem_read = 1; mem_write = 1; size = SZ_WORD; unsigned_ld = ~uns;
      addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A;
      dmem_ack   = ack_it && (i == nwait);
      dmem_rdata = (i == nwait) ? rmem : 32'hDEAD_0000;
      #1;
      stalls += int'(stall);
      cap_req = dmem_req; cap_we = dmem_we; cap_addr = dmem_addr;
      cap_be = dmem_be; cap_wdata = dmem_wdata;
    end
  endtask

  task automatic bad_op(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic [31:0] a);
    @(negedge clk);
    start = 1; mem_read = rd; mem_write = wr; size = sz; addr = a; wdata = 32'h1111_2222;
    #1;
    check({tag, "_stall"}, 32'(stall), 32'd0);
    idle();
    check({tag, "_addr_err"}, 32'(addr_err), 32'd1);
    check({tag, "_req"}, 32'(dmem_req), 32'd0);
  endtask

  initial begin
    rst = 1;
    start = 0; mem_read = 0; mem_write = 0; size = SZ_BYTE; unsigned_ld = 0;
    addr = 0; wdata = 0; dmem_ack = 0; dmem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rdata", rdata_out, 32'd0);
    check("rst_pulses", {29'd0, done, addr_err, bus_err}, 32'd0);
    check("rst_bus", {dmem_addr ^ dmem_wdata}, 32'd0);
    check("rst_be_we", {27'd0, dmem_be, dmem_we}, 32'd0);
    rst = 0;
    idle();

    // 1: signed then unsigned byte load at lane 3, immediate ack
    d0 = done_cnt;
    mem_op(1, 0, SZ_BYTE, 0, 32'h0000_1003, 0, 0, 1, 32'h80FF_1234);
    check("t1_req", 32'(cap_req), 32'd1);
    check("t1_addr", cap_addr, 32'h0000_1000);
    check("t1_be", 32'(cap_be), 32'hF);
    check("t1_we", 32'(cap_we), 32'd0);
    check("t1_stalls", 32'(stalls), 32'd2);
    idle();
    check("t1_done", 32'(done), 32'd1);
    check("t1_rdata", rdata_out, 32'hFFFF_FF80);
    check("t1_stall_after", 32'(stall), 32'd0);
    mem_op(1, 0, SZ_BYTE, 1, 32'h0000_1003, 0, 0, 1, 32'h80FF_1234);
    idle();
    check("t1u_rdata", rdata_out, 32'h0000_0080);
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd2);

    // 2: halfword store, ack on the 4th busy cycle (same cycle the timeout would fire)
    d0 = done_cnt; b0 = berr_cnt;
    mem_op(0, 1, SZ_HALF, 0, 32'h0000_2002, 32'hDEAD_BEEF, 3, 1, 32'h0);
    check("t2_wdata", cap_wdata, 32'hBEEF_BEEF);
    check("t2_be", 32'(cap_be), 32'hC);
    check("t2_we", 32'(cap_we), 32'd1);
    check("t2_addr", cap_addr, 32'h0000_2000);
    check("t2_stalls", 32'(stalls), 32'd5);
    idle();
    idle();
    check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t2_no_berr", 32'(berr_cnt - b0), 32'd0);
    check("t2_rdata_kept", rdata_out, 32'h0000_0080);

    // 3: misaligned and illegal ops never reach memory
    a0 = aerr_cnt; r0 = req_cnt;
    bad_op("t3_lw", 1, 0, SZ_WORD, 32'h0000_3001);
    bad_op("t3_lh", 1, 0, SZ_HALF, 32'h0000_3003);
    bad_op("t3_sz11", 1, 0, SZ_ILL, 32'h0000_3000);
    bad_op("t3_rw", 1, 1, SZ_WORD, 32'h0000_3000);
    bad_op("t3_none", 0, 0, SZ_BYTE, 32'h0000_3000);
    check("t3_aerr_cnt", 32'(aerr_cnt - a0), 32'd5);
    check("t3_req_cnt", 32'(req_cnt - r0), 32'd0);

    // 4: no ack, abort after 4 busy cycles
    d0 = done_cnt; b0 = berr_cnt;
    mem_op(1, 0, SZ_BYTE, 0, 32'h0000_5000, 0, 3, 0, 32'hFFFF_FFFF);
    check("t4_req_last", 32'(cap_req), 32'd1);
    check("t4_stalls", 32'(stalls), 32'd5);
    idle();
    check("t4_bus_err", 32'(bus_err), 32'd1);
    check("t4_req_drop", 32'(dmem_req), 32'd0);
    idle();
    check("t4_berr_cnt", 32'(berr_cnt - b0), 32'd1);
    check("t4_no_done", 32'(done_cnt - d0), 32'd0);
    check("t4_rdata_kept", rdata_out, 32'h0000_0080);

    // 5: reset in the 2nd busy cycle, then a clean word load
    d0 = done_cnt;
    @(negedge clk);
    start = 1; mem_read = 1; mem_write = 0; size = SZ_WORD; addr = 32'h0000_0010;
    @(negedge clk);
    start = 0; mem_read = 0; #1;
    check("t5_busy1_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0; #1;
    check("t5_req", 32'(dmem_req), 32'd0);
    check("t5_stall", 32'(stall), 32'd0);
    check("t5_rdata", rdata_out, 32'd0);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    mem_op(1, 0, SZ_WORD, 0, 32'h0000_0000, 0, 0, 1, 32'h1234_5678);
    idle();
    check("t5_reload", rdata_out, 32'h1234_5678);

    // 6: spurious ack in idle, then back-to-back LH / LHU
    d0 = done_cnt; r0 = req_cnt;
    @(negedge clk);
    dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    #1;
    check("t6_spur_done", 32'(done_cnt - d0), 32'd0);
    check("t6_spur_req", 32'(req_cnt - r0), 32'd0);
    check("t6_spur_rdata", rdata_out, 32'h1234_5678);
    mem_op(1, 0, SZ_HALF, 0, 32'h0000_4002, 0, 0, 1, 32'h8001_7FFF);
    mem_op(1, 0, SZ_HALF, 1, 32'h0000_4000, 0, 0, 1, 32'h8001_7FFF);
    check("t6_lh_done", 32'(prev_done), 32'd1);
    check("t6_lh_rdata", prev_rdata, 32'hFFFF_8001);
    check("t6_b2b_stalls", 32'(stalls), 32'd2);
    check("t6_b2b_addr", cap_addr, 32'h0000_4000);
    idle();
    check("t6_lhu_rdata", rdata_out, 32'h0000_7FFF);
    idle();
    check("t6_done_cnt", 32'(done_cnt - d0), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
